// File: rtl/game_pkg.sv
// Shared display codes, session states and helpers for the reaction-game family.
// Game modes and the session sequencer all decode the same 4-bit digit codes.
package game_pkg;

    localparam logic [3:0] CODE_IDLE    = 4'd0;
    localparam logic [3:0] CODE_TARGET1 = 4'd1;
    localparam logic [3:0] CODE_TARGET2 = 4'd2;
    localparam logic [3:0] CODE_TARGET3 = 4'd3;
    localparam logic [3:0] CODE_TARGET4 = 4'd4;
    localparam logic [3:0] CODE_RIGHT   = 4'd10;
    localparam logic [3:0] CODE_WRONG   = 4'd11;
    localparam logic [3:0] CODE_MENU    = 4'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        SCORE = 2'b10
    } session_state_t;

    // A result code is either of the two verdicts the game shows after a round.
    function automatic logic is_res(input logic [3:0] code);
        return (code == CODE_RIGHT) || (code == CODE_WRONG);
    endfunction

endpackage

// File: rtl/game_session_ctrl_btn_edge.sv
// Registered rising-edge detector for a bank of synchronous button levels.
// The edge output is combinational from the live level and last cycle's level.
module btn_edge #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);

    logic [W-1:0] din_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_q <= '0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/game_session_ctrl.sv
// Session sequencer around the reaction game: owns buttons and display digit,
// runs ROUNDS rounds, tallies right answers, then shows the final score.
module game_session_ctrl
    import game_pkg::*;
#(
    parameter int ROUNDS     = 5,
    parameter int SCORE_HOLD = 20_000_000,
    parameter int ABORT_HOLD = 30_000_000,
    parameter int CNT_W      = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic [3:0] game_value,
    output logic       game_rst,
    output logic [3:0] game_btn,
    output logic [3:0] value,
    output logic [3:0] score,
    output logic       session_done
);

    localparam logic [3:0]       ROUNDS_C   = 4'(ROUNDS);
    localparam logic [CNT_W-1:0] SCORE_LAST = CNT_W'(SCORE_HOLD - 1);
    localparam logic [CNT_W-1:0] ABORT_LAST = CNT_W'(ABORT_HOLD - 1);
    localparam logic [3:0]       START_MASK = 4'b0001;

    session_state_t   state, state_next;
    logic [3:0]       value_next, score_next;
    logic [3:0]       round_cnt, round_next;
    logic [CNT_W-1:0] hold_cnt, hold_next;
    logic             done_next;
    logic [3:0]       gv_q;
    logic [3:0]       btn_rise;
    logic             btn1_rise;
    logic             all_held;
    logic             res_in, res_out;

    btn_edge #(.W(4)) u_btn_edge (
        .clk  (clk),
        .reset(reset),
        .din  (btn),
        .rise (btn_rise)
    );

    // btn1 is the start/skip button; the other edges are free for future modes.
    assign btn1_rise = |(btn_rise & START_MASK);
    assign all_held  = (btn == 4'b1111);
    assign res_in    = is_res(game_value) & ~is_res(gv_q);
    assign res_out   = is_res(gv_q) & ~is_res(game_value);

    assign game_rst  = (state != PLAY);
    assign game_btn  = (state == PLAY) ? btn : 4'b0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            value        <= CODE_MENU;
            score        <= 4'd0;
            session_done <= 1'b0;
            round_cnt    <= 4'd0;
            hold_cnt     <= '0;
            gv_q         <= 4'd0;
        end else begin
            state        <= state_next;
            value        <= value_next;
            score        <= score_next;
            session_done <= done_next;
            round_cnt    <= round_next;
            hold_cnt     <= hold_next;
            gv_q         <= game_value;
        end
    end

    always_comb begin
        state_next = state;
        value_next = value;
        score_next = score;
        round_next = round_cnt;
        hold_next  = hold_cnt;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                value_next = CODE_MENU;
                if (btn1_rise) begin
                    state_next = PLAY;
                    score_next = 4'd0;
                    round_next = 4'd0;
                    hold_next  = '0;
                end
            end

            PLAY: begin
                value_next = game_value;
                hold_next  = all_held ? hold_cnt + CNT_W'(1) : '0;
                // Abort wins over any result edge landing in the same cycle.
                if (all_held && (hold_cnt == ABORT_LAST)) begin
                    state_next = IDLE;
                    hold_next  = '0;
                end else begin
                    if (res_in && (round_cnt < ROUNDS_C)) begin
                        round_next = round_cnt + 4'd1;
                        if ((game_value == CODE_RIGHT) && (score < ROUNDS_C)) begin
                            score_next = score + 4'd1;
                        end
                    end
                    // Leave only when the last verdict disappears, so it is seen in full.
                    if (res_out && (round_cnt == ROUNDS_C)) begin
                        state_next = SCORE;
                        hold_next  = '0;
                        done_next  = 1'b1;
                    end
                end
            end

            SCORE: begin
                value_next = score;
                if ((hold_cnt == SCORE_LAST) || btn1_rise) begin
                    state_next = IDLE;
                    hold_next  = '0;
                end else begin
                    hold_next = hold_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                value_next = CODE_MENU;
                hold_next  = '0;
            end
        endcase
    end

endmodule
